// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
//  Module      : uart_defs (package)
//  Description : Shared UART definitions: FSM state encoding, frame data
//                width and the default baud divisor (100 MHz / 9600).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS        = 8;
  localparam int BAUD_DIV_DEFAULT = 10417;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period counter running 0..BAUD_DIV-1. Synchronous clear
//                has priority over enable. tick is high while the count sits
//                at BAUD_DIV-1, i.e. on the last cycle of a bit period.
//  Ports       : clk     - system clock, rising edge
//                reset_n - asynchronous active-low reset
//                clr     - synchronous clear to zero
//                en      - count enable
//                tick    - high when count == BAUD_DIV-1
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int BAUD_DIV = 10417
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_drain
//  Description : UART transmitter draining an 8-bit TX FIFO from its read
//                side. Pops the head entry when idle and enabled, then sends
//                it 8N1/8N2, LSB first, at BAUD_DIV clocks per bit.
//  Ports       : clk        - system clock, rising edge
//                reset_n    - asynchronous active-low reset
//                tx_en      - allows a new frame to start (sampled in IDLE)
//                fifo_empty - FIFO empty flag
//                fifo_rdata - FIFO head data (valid while not empty)
//                fifo_pop   - one-cycle pop strobe (combinational)
//                tx         - serial line, idles high (registered)
//                tx_busy    - frame in progress (registered)
//                tx_done    - one-cycle pulse after the last stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain
  import uart_defs::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rdata,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_q,    state_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [BIT_W-1:0]     bit_idx_q,  bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  logic                 baud_tick;

  // Counter is held at zero in IDLE so the first bit period starts cleanly
  // on the edge that leaves IDLE.
  uart_baud_cnt #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q == ST_IDLE),
    .en      (state_q != ST_IDLE),
    .tick    (baud_tick)
  );

  // Gated by reset_n so the FIFO is never popped while this block is held
  // in reset (the state already reads IDLE during reset).
  assign fifo_pop = reset_n & (state_q == ST_IDLE) & tx_en & ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (fifo_pop) begin
          shift_d    = fifo_rdata;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = ST_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            // Next bit is shift_q[1], which becomes shift_d[0].
            tx_d = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo_drain
//  Description : Bench for uart_tx_fifo_drain. Two instances (1 and 2 stop
//                bits, BAUD_DIV=4) each read a FIFO model; a per-instance
//                monitor checks every line cycle against the byte popped from
//                the expected-frame scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] tx_en = 2'b00;
  logic [1:0] fifo_empty;
  logic [1:0] fifo_pop;
  logic [1:0] tx;
  logic [1:0] tx_busy;
  logic [1:0] tx_done;
  logic [7:0] fifo_rdata [2];

  logic [7:0] mem [2][64];
  int         wp [2] = '{0, 0};
  logic [7:0] exp_q [2][$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int FLEN = (9 + gi + 1) * BD;

    int         rp = 0;
    logic [7:0] cur;
    int         pos;
    bit         active;
    bit         prev_pop;

    uart_tx_fifo_drain #(
      .BAUD_DIV  (BD),
      .STOP_BITS (gi + 1)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tx_en      (tx_en[gi]),
      .fifo_empty (fifo_empty[gi]),
      .fifo_rdata (fifo_rdata[gi]),
      .fifo_pop   (fifo_pop[gi]),
      .tx         (tx[gi]),
      .tx_busy    (tx_busy[gi]),
      .tx_done    (tx_done[gi])
    );

    assign fifo_empty[gi] = (wp[gi] == rp);
    assign fifo_rdata[gi] = mem[gi][rp[5:0]];

    always @(posedge clk) begin
      if (fifo_pop[gi]) rp <= rp + 1;
    end

    // Line monitor: pos counts samples since the start edge; bit number is
    // pos/BD (0 = start, 1..8 = data LSB first, then stop bits).
    initial begin
      active = 0; pos = 0; cur = '0; prev_pop = 0;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          active = 0;
          check_val($sformatf("u%0d_rst_tx", gi), tx[gi], 1);
          check_val($sformatf("u%0d_rst_busy", gi), tx_busy[gi], 0);
          check_val($sformatf("u%0d_rst_done", gi), tx_done[gi], 0);
          check_val($sformatf("u%0d_rst_pop", gi), fifo_pop[gi], 0);
        end else if (active) begin
          pos++;
          if (pos < FLEN) begin
            int b;
            logic e;
            b = pos / BD;
            e = (b == 0) ? 1'b0 : (b <= 8) ? cur[b-1] : 1'b1;
            check_val($sformatf("u%0d_tx_pos%0d", gi, pos), tx[gi], e);
            check_val($sformatf("u%0d_busy", gi), tx_busy[gi], 1);
            check_val($sformatf("u%0d_done_early", gi), tx_done[gi], 0);
            check_val($sformatf("u%0d_pop_busy", gi), fifo_pop[gi], 0);
          end else begin
            check_val($sformatf("u%0d_done", gi), tx_done[gi], 1);
            check_val($sformatf("u%0d_busy_end", gi), tx_busy[gi], 0);
            check_val($sformatf("u%0d_tx_gap", gi), tx[gi], 1);
            check_val($sformatf("u%0d_pop_gap", gi), fifo_pop[gi], tx_en[gi] & ~fifo_empty[gi]);
            active = 0;
          end
        end else if (tx[gi] == 1'b0) begin
          check_val($sformatf("u%0d_pop_before_start", gi), prev_pop, 1);
          check_val($sformatf("u%0d_busy_start", gi), tx_busy[gi], 1);
          if (exp_q[gi].size() == 0) begin
            check_val($sformatf("u%0d_unexpected_frame", gi), 1, 0);
            cur = '0;
          end else begin
            cur = exp_q[gi].pop_front();
          end
          pos = 0;
          active = 1;
        end else begin
          check_val($sformatf("u%0d_idle_busy", gi), tx_busy[gi], 0);
          check_val($sformatf("u%0d_idle_done", gi), tx_done[gi], 0);
          check_val($sformatf("u%0d_idle_pop", gi), fifo_pop[gi], tx_en[gi] & ~fifo_empty[gi]);
        end
        prev_pop = fifo_pop[gi];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit sent);
    mem[i][wp[i][5:0]] = d;
    wp[i] = wp[i] + 1;
    if (sent) exp_q[i].push_back(d);
  endtask

  task automatic wait_busy(input int i);
    int n = 0;
    while (!tx_busy[i] && n < 200) begin
      step(1);
      n++;
    end
    check_val("busy_timeout", (n < 200) ? 1 : 0, 1);
  endtask

  task automatic wait_drain(input int i);
    int n = 0;
    while ((exp_q[i].size() != 0 || tx_busy[i]) && n < 2000) begin
      step(1);
      n++;
    end
    check_val("drain_timeout", (n < 2000) ? 1 : 0, 1);
    step(2);
  endtask

  initial begin
    // Reset held with data waiting and transmission enabled.
    step(1);
    push(0, 8'hA5, 1);
    tx_en[0] = 1'b1;
    step(10);
    check_val("rst_no_pop", g_dut[0].rp, 0);
    reset_n = 1'b1;

    // Single byte, one stop bit.
    wait_drain(0);
    check_val("a5_pops", g_dut[0].rp, 1);

    // Back-to-back frames.
    push(0, 8'h55, 1);
    push(0, 8'h0F, 1);
    wait_drain(0);
    check_val("b2b_pops", g_dut[0].rp, 3);

    // Disabled with data waiting, then enable and drop mid-frame.
    tx_en[0] = 1'b0;
    push(0, 8'h81, 1);
    push(0, 8'h7E, 0);
    step(20);
    check_val("dis_no_pop", g_dut[0].rp, 3);
    tx_en[0] = 1'b1;
    wait_busy(0);
    step(12);
    tx_en[0] = 1'b0;
    wait_drain(0);
    step(5);
    check_val("drop_en_pops", g_dut[0].rp, 4);
    exp_q[0].push_back(8'h7E);
    tx_en[0] = 1'b1;
    wait_drain(0);
    check_val("leftover_pops", g_dut[0].rp, 5);

    // Reset during data bit 3 of 0xFF; 0x3C must follow, 0xFF not resent.
    push(0, 8'hFF, 1);
    push(0, 8'h3C, 1);
    wait_busy(0);
    step(17);
    reset_n = 1'b0;
    #1;
    check_val("async_rst_tx", tx[0], 1);
    check_val("async_rst_busy", tx_busy[0], 0);
    step(3);
    reset_n = 1'b1;
    wait_drain(0);
    check_val("after_rst_pops", g_dut[0].rp, 7);

    // Two stop bits.
    push(1, 8'h00, 1);
    push(1, 8'hC3, 1);
    tx_en[1] = 1'b1;
    wait_drain(1);
    check_val("stop2_pops", g_dut[1].rp, 2);
    check_val("stop2_tx_idle", tx[1], 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
UART transmitter that drains the existing 8-bit TX FIFO from its read side. When the FIFO is non-empty and transmission is enabled, it reads the head entry, pops it, and serialises it as 8N1 or 8N2, LSB first, at a parameterised baud. It sits between the TX FIFO's pop/empty/pop_data outputs and the board's UART TX pin.

Parameters:
BAUD_DIV, 10417, clock cycles per UART bit (100 MHz / 9600); legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
tx_en  input  1  permits the start of a new frame; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  8  FIFO head data; combinational, valid whenever fifo_empty=0
fifo_pop  output  1  one-cycle pop strobe to the FIFO
tx  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in progress (START..STOP)
tx_done  output  1  one-cycle pulse on the cycle after the final stop-bit cycle

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, tx=1, tx_busy=0, tx_done=0, fifo_pop=0, baud counter=0, bit index=0, shift register=0.
- fifo_pop is combinational: (state==IDLE) & tx_en & ~fifo_empty. It is never asserted outside IDLE. The FIFO pop and the data latch happen on the same rising edge.
- tx, tx_busy and tx_done are registered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If tx_en & ~fifo_empty at an edge: shift register <= fifo_rdata, baud counter <= 0, bit index <= 0, state -> START.
  - At that same edge, tx goes 0 and tx_busy goes 1.
- Baud counter:
  - Runs 0..BAUD_DIV-1, width $clog2(BAUD_DIV).
  - A bit boundary occurs when the counter equals BAUD_DIV-1; the counter then wraps to 0.
  - The counter is held at 0 in IDLE.
- START: tx=0 for BAUD_DIV cycles, then -> DATA with tx = shift[0].
- DATA:
  - Each bit is held for BAUD_DIV cycles, LSB first.
  - At each boundary the register shifts right and the bit index increments.
  - At the boundary with bit index = 7, state -> STOP and tx = 1.
- STOP:
  - tx=1 for STOP_BITS*BAUD_DIV cycles, tracked with a stop-bit count.
  - At the last boundary: state -> IDLE, tx_busy -> 0, and tx_done is high for exactly the next cycle.
- Frame length from the start edge to the IDLE return is (9+STOP_BITS)*BAUD_DIV cycles.
- Back-to-back frames: the module spends exactly one cycle in IDLE with tx=1 between frames. The frame period is therefore (9+STOP_BITS)*BAUD_DIV+1 cycles.
- tx_en deasserted mid-frame: the current frame completes normally and no further pop occurs.
- fifo_empty and fifo_rdata are ignored outside IDLE. Changes at the FIFO during a frame do not alter the byte being sent.
- reset_n asserted mid-frame:
  - tx returns to 1 immediately and all state is cleared.
  - The byte already popped is lost and is not re-read.
  - The FIFO is not reset by this block.
- No parity, no break generation, no CTS.

Decomposition:
- Shared package (uart_defs): FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), DATA_BITS=8, and the default BAUD_DIV value.
- One sub-module: uart_baud_cnt. A parameterised counter with a synchronous clear and an enable, outputting a tick when count==BAUD_DIV-1. This sub-module is reused by the future RX side.

Test Plan:
All cases use BAUD_DIV=4 unless stated.
1. Reset: hold reset_n=0 with the FIFO non-empty and tx_en=1 -> tx=1, tx_busy=0, tx_done=0, fifo_pop=0 throughout; no frame starts until the release.
2. Single byte 0xA5, STOP_BITS=1, tx_en=1 -> fifo_pop high for exactly 1 cycle. tx is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. tx_done pulses 40 cycles after the start edge; tx_busy is high for exactly 40 cycles.
3. FIFO holds 0x55 then 0x0F -> two pops 41 cycles apart, with one high idle cycle between the stop bit and the second start bit. The second frame's data bits are 1,1,1,1,0,0,0,0.
4. tx_en=0 with the FIFO non-empty for 20 cycles -> no pop, tx=1. Assert tx_en, then drop it during DATA -> the frame finishes and tx_done pulses, with no second pop although the FIFO is non-empty.
5. STOP_BITS=2, byte 0x00 -> tx low for 36 cycles (start + 8 data bits), high for 8 cycles; tx_done pulses 44 cycles after the start edge.
6. Assert reset_n=0 during data bit 3 of 0xFF -> tx=1 and tx_busy=0 asynchronously, before the next clk edge. After release, with 0x3C next in the FIFO, a new frame sends 0x3C and 0xFF is not re-sent.
